op2_seq: RTL and testbench

OP2_SEQ -- requirements
Module: op2_seq

---
 rtl/op2_seq.sv | 113 +++++++++++
 tb/tb_op2_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/op2_seq.sv
// Sample bank sequencer for a 16-input adder stage: fills a bank of up to 16 samples,
// waits ADD_LAT cycles for the adder result, then holds that result until downstream takes it.
module op2_seq #(
    parameter int ADD_LAT = 1,
    parameter int DATA_W  = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [16*DATA_W-1:0] bank_out,
    input  logic [DATA_W-1:0]    add_result,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        OUT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic [2:0]          wait_cnt;
    logic [DATA_W-1:0]   bank [16];
    logic                in_hs;
    logic                frame_done;
    logic                out_hs;
    logic                capture;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        in_hs      = 1'b0;
        frame_done = 1'b0;
        out_hs     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            FILL: begin
                in_ready   = 1'b1;
                in_hs      = in_valid;
                frame_done = in_valid && (cnt == 4'd15 || in_last);
                if (frame_done) state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 3'd1) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    out_hs    = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
        // Handshakes and status are suppressed for the whole reset window.
        if (reset) begin
            in_ready   = 1'b0;
            out_valid  = 1'b0;
            in_hs      = 1'b0;
            frame_done = 1'b0;
            out_hs     = 1'b0;
            capture    = 1'b0;
        end
    end

    assign busy = !reset && !(state == FILL && cnt == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    // NOTE: the bank is a handful of registers that must read as zero for short frames, so it is cleared on reset like any other state.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= 4'd0;
            wait_cnt <= 3'd0;
            out_data <= '0;
            for (int k = 0; k < 16; k++) bank[k] <= '0;
        end else begin
            if (in_hs) begin
                bank[cnt] <= in_data;
                cnt       <= cnt + 4'd1;
            end
            if (frame_done)         wait_cnt <= 3'(ADD_LAT);
            else if (state == WAIT) wait_cnt <= wait_cnt - 3'd1;
            if (capture) out_data <= add_result;
            if (out_hs) begin
                cnt <= 4'd0;
                for (int k = 0; k < 16; k++) bank[k] <= '0;
            end
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_bank_out
        assign bank_out[k*DATA_W +: DATA_W] = bank[k];
    end

endmodule

// File: tb/tb_op2_seq.sv
// Bench for op2_seq: two instances (ADD_LAT=1 and ADD_LAT=4) each fed by a model adder
// (sum >> 3, trimmed to DATA_W); expected results go through a scoreboard queue.
module tb_op2_seq;

    localparam int DW = 12;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset;
    logic [1:0]           in_valid, in_last, out_ready;
    logic [1:0]           in_ready, out_valid, busy;
    logic [1:0][DW-1:0]   in_data, add_result, out_data;
    logic [1:0][16*DW-1:0] bank_out;

    op2_seq #(.ADD_LAT(1), .DATA_W(DW)) dut_lat1 (
        .clock(clock), .reset(reset),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
        .bank_out(bank_out[0]), .add_result(add_result[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0])
    );

    op2_seq #(.ADD_LAT(4), .DATA_W(DW)) dut_lat4 (
        .clock(clock), .reset(reset),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
        .bank_out(bank_out[1]), .add_result(add_result[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1])
    );

    function automatic logic [DW-1:0] model_adder(input logic [16*DW-1:0] b);
        logic [DW+3:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) s = s + {4'd0, b[k*DW +: DW]};
        return DW'(s >> 3);
    endfunction

    assign add_result[0] = model_adder(bank_out[0]);
    assign add_result[1] = model_adder(bank_out[1]);

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [DW-1:0] data;
        int            hs;
        int            lat;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives n samples back-to-back from a negedge; returns the cycle of the final handshake.
    task automatic send_frame(input int d, input int n, input int vals[16], input bit last,
                              output int hs_cyc);
        int waits;
        hs_cyc = -1;
        for (int i = 0; i < n; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = DW'(vals[i]);
            in_last[d]  = last && (i == n - 1);
            waits = 0;
            while (!in_ready[d] && waits < 50) begin
                @(negedge clock);
                waits++;
            end
            if (!in_ready[d]) check("in_ready_timeout", in_ready[d], 1);
            hs_cyc = cyc;
            @(negedge clock);
        end
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic wait_out(input int d);
        int   waits;
        exp_t e;
        waits = 0;
        while (!out_valid[d] && waits < 40) begin
            @(negedge clock);
            waits++;
        end
        if (!out_valid[d]) begin
            check("out_valid_timeout", out_valid[d], 1);
        end else if (exp_q.size() == 0) begin
            check("unexpected_output", out_valid[d], 0);
        end else begin
            e = exp_q.pop_front();
            check("out_data", out_data[d], e.data);
            check("latency", cyc - e.hs, e.lat + 1);
        end
    endtask

    task automatic release_out(input int d);
        out_ready[d] = 1'b1;
        @(negedge clock);
        out_ready[d] = 1'b0;
    endtask

    initial begin
        int vals[16];
        int hs, rel, s;
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        out_ready = '0;
        in_data   = '0;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", in_ready[d], 0);
            check("rst_out_valid", out_valid[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_bank", bank_out[d], 0);
            check("rst_out_data", out_data[d], 0);
        end
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) check("post_rst_in_ready", in_ready[d], 1);

        // Full frame of 8s, ADD_LAT=1.
        for (int k = 0; k < 16; k++) vals[k] = 8;
        send_frame(0, 16, vals, 1'b0, hs);
        exp_q.push_back('{data: 12'd16, hs: hs, lat: 1});
        check("wait_in_ready", in_ready[0], 0);
        check("wait_busy", busy[0], 1);
        wait_out(0);
        release_out(0);
        check("cleared_bank", bank_out[0], 0);
        check("cleared_busy", busy[0], 0);
        check("cleared_in_ready", in_ready[0], 1);

        // Short frame: slots 3..15 must stay zero.
        vals[0] = 100; vals[1] = 200; vals[2] = 300;
        send_frame(0, 3, vals, 1'b1, hs);
        exp_q.push_back('{data: 12'd75, hs: hs, lat: 1});
        check("short_bank_hi", bank_out[0][16*DW-1:3*DW], 0);
        check("short_bank_lo", bank_out[0][3*DW-1:0], {12'd300, 12'd200, 12'd100});
        wait_out(0);

        // Backpressure with the next frame's sample already offered.
        in_valid[0] = 1'b1; in_data[0] = 12'd40; in_last[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_out_valid", out_valid[0], 1);
            check("bp_out_data", out_data[0], 12'd75);
            check("bp_in_ready", in_ready[0], 0);
        end
        out_ready[0] = 1'b1;
        check("out_hs_in_ready", in_ready[0], 0);
        rel = cyc;
        @(negedge clock);
        out_ready[0] = 1'b0;
        vals[0] = 40;
        send_frame(0, 1, vals, 1'b1, hs);
        check("accept_after_release", hs, rel + 1);
        exp_q.push_back('{data: 12'd5, hs: hs, lat: 1});
        wait_out(0);
        release_out(0);

        // Stray in_last without in_valid.
        in_last[0] = 1'b1;
        repeat (2) @(negedge clock);
        in_last[0] = 1'b0;
        check("stray_last_busy", busy[0], 0);
        check("stray_last_bank", bank_out[0], 0);

        // Full random frame, ADD_LAT=4.
        s = 0;
        for (int k = 0; k < 16; k++) begin
            vals[k] = int'($urandom_range(0, 4095));
            s += vals[k];
        end
        send_frame(1, 16, vals, 1'b0, hs);
        exp_q.push_back('{data: DW'(s >> 3), hs: hs, lat: 4});
        wait_out(1);
        release_out(1);

        // Reset while waiting on the adder discards the frame.
        for (int k = 0; k < 16; k++) vals[k] = 'h123;
        send_frame(1, 16, vals, 1'b0, hs);
        check("pre_rst_busy", busy[1], 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("no_out_after_rst", out_valid[1], 0);
        end
        check("rst_wait_bank", bank_out[1], 0);
        check("rst_wait_busy", busy[1], 0);
        check("rst_wait_out_data", out_data[1], 0);
        for (int k = 0; k < 16; k++) vals[k] = 'hFFF;
        send_frame(1, 16, vals, 1'b0, hs);
        exp_q.push_back('{data: 12'hFFE, hs: hs, lat: 4});
        wait_out(1);
        release_out(1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
